seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a common-anode 4-digit 7-segment display. It consumes 4-bit hex values from the counters and drives segment and anode lines directly.
Values are accepted through a valid strobe and staged in a pending register. The displayed value changes only at frame boundaries, so the display never shows a half-updated number.
It sits between the counter and display logic and the board pins, on the undivided system clock; no divided clock is used.

Parameters:
DIGITS, 4, number of digits scanned (2..8); hex_in width is 4*DIGITS
SCAN_DIV, 100000, clocks per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 4, clocks at slot start with all anodes off (anti-ghosting)

Ports:
clkIn  in  1  system clock; the block's only clock
rst_n  in  1  reset, asynchronous assert, active-low
hex_in  in  4*DIGITS  nibble k = digit k; digit 0 is least significant (rightmost)
hex_valid  in  1  one-clock strobe; captures hex_in into pending
dp_in  in  DIGITS  decimal point per digit, active-high
lz_blank  in  1  1 = blank leading zero digits
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
an  out  DIGITS  anode enables, active-low, one-hot-low when driving
frame_start  out  1  one-clock pulse when digit 0 slot begins with new display data loaded

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: one clock (clkIn); reset rst_n asynchronously clears all state.
- Reset values:
  - an all 1s; seg 7'h7F; dp 1; frame_start 0.
  - tick 0; digit index 0; display and pending registers 0; pending flag 0.
- tick counter runs 0..SCAN_DIV-1 and wraps. On wrap, the digit index increments, wrapping DIGITS-1 -> 0.
- Slot phases:
  - BLANK: tick < BLANK_CYCLES. an all 1s, seg 7'h7F, dp 1.
  - DRIVE: remaining ticks. an[idx]=0 and all other anodes 1; seg = decode(display nibble idx); dp = ~dp_in[idx].
- Outputs are registered: values for a given tick appear one clock later. an and seg change on the same edge.
- Decode, active-high before inversion:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Output is the bitwise inverse (e.g. 0 -> 40, 8 -> 00, F -> 0E).
- Staging:
  - hex_valid=1 latches hex_in into pending and sets the pending flag.
  - Further strobes before the frame boundary overwrite pending; the last one wins.
- Frame boundary is the clock where the index wraps DIGITS-1 -> 0:
  - If pending flag set: display <= pending, flag cleared.
  - If hex_valid is asserted on the boundary clock: display <= hex_in directly and flag cleared; the strobe is not lost.
  - frame_start pulses one clock later, every frame, whether or not data changed.
- Leading-zero blanking (lz_blank=1):
  - Digit k is blanked (seg 7F) when nibbles k..DIGITS-1 are all 0 and k != 0.
  - Digit 0 is never blanked. dp still follows dp_in on blanked digits.
  - lz_blank is sampled live, not staged.
- dp_in is sampled live each DRIVE clock.
- rst_n asserted mid-slot: all outputs go to reset values immediately, with no clock required. After release, scanning restarts at digit 0 in the BLANK phase.
- No combinational path from any input to any output.

Test Plan:
(All scenarios use SCAN_DIV=8, BLANK_CYCLES=2, DIGITS=4.)
1. Reset release, idle:
   - Required: an=1111 for ticks 0-1 of each slot, then an=1110 with seg=40 (digit "0") for 6 clocks.
   - Then digit 1 with an=1101, and so on; frame_start every 32 clocks.
2. hex_valid with hex_in=16'h8F1A mid-frame:
   - Required: display unchanged until the next boundary.
   - Next frame shows seg 0x08 (A) on an=1110, 0x79 (1) on 1101, 0x0E (F) on 1011, 0x00 (8) on 0111.
3. Back-to-back strobes 16'h1111 then 16'h2222 in the same frame:
   - Required: only 2222 appears, with seg=24 on all digits.
   - Strobe 16'h3333 exactly on the boundary clock: 3333 is shown in that frame (seg=30), with no one-frame lag.
4. lz_blank=1, value 16'h0050:
   - Required: digits 3 and 2 are seg=7F, digit 1 is seg=12 (5), digit 0 is seg=40.
   - Value 16'h0000: only digit 0 is lit.
   - lz_blank=0: all four digits show 40.
5. dp_in=4'b0100:
   - Required: dp=0 only while an=1011 in DRIVE; dp=1 during BLANK and in all other slots.
6. rst_n pulsed low at tick 5 of digit 2:
   - Required: an=1111, seg=7F, dp=1 asynchronously, before the next edge.
   - After release: display=0, pending flag clear, scan restarts at digit 0, tick 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Each digit owns a slot of SCAN_DIV clocks. The first BLANK_CYCLES clocks of a
// slot keep every anode off so the previous digit's segments cannot ghost into
// the next one. The remaining clocks drive one anode low with that digit's
// segments and decimal point.
//
// New values are staged in a pending register and copied into the display
// register only at the frame boundary (the clock where the digit index wraps
// from DIGITS-1 to 0), so a frame never mixes old and new digits.
//
// Input strobe semantics: hex_valid is a one-clock, valid-only strobe (there is
// no ready; the block always accepts). Every clock with hex_valid=1 captures
// hex_in; the last strobe before a boundary wins. A strobe on the boundary
// clock itself goes straight to the display register.
//
// Ports
//   clkIn        system clock, the only clock
//   rst_n        asynchronous active-low reset
//   hex_in       4*DIGITS bits, nibble k = digit k (digit 0 rightmost)
//   hex_valid    capture strobe for hex_in
//   dp_in        decimal point per digit, active-high, sampled live
//   lz_blank     1 = blank leading zero digits, sampled live
//   seg          {g,f,e,d,c,b,a}, active-low, registered
//   dp           decimal point, active-low, registered
//   an           anode enables, active-low, registered
//   frame_start  one-clock pulse as the digit 0 slot starts with new data
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                  clkIn,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   hex_in,
   input  logic                  hex_valid,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_start
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   logic [TW-1:0]         tick;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   display_q;
   logic [4*DIGITS-1:0]   pending_q;
   logic                  pending_flag;

   logic                  tick_wrap;
   logic                  boundary;
   logic                  in_blank;

   // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign tick_wrap = (tick == TW'(SCAN_DIV - 1));
   assign boundary  = tick_wrap && (idx == IW'(DIGITS - 1));
   assign in_blank  = (tick < TW'(BLANK_CYCLES));

   // Scan position: tick within the slot, idx selects the digit.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         tick <= '0;
         idx  <= '0;
      end else if (tick_wrap) begin
         tick <= '0;
         if (idx == IW'(DIGITS - 1)) idx <= '0;
         else                        idx <= idx + IW'(1);
      end else begin
         tick <= tick + TW'(1);
      end
   end

   // Staging. A strobe on the boundary clock bypasses pending so it shows in
   // the frame that is just starting rather than one frame later.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         display_q    <= '0;
         pending_q    <= '0;
         pending_flag <= 1'b0;
      end else if (boundary) begin
         if (hex_valid)         display_q <= hex_in;
         else if (pending_flag) display_q <= pending_q;
         pending_flag <= 1'b0;
      end else if (hex_valid) begin
         pending_q    <= hex_in;
         pending_flag <= 1'b1;
      end
   end

   // Per-digit selection. lz_mask[k] marks digit k as a leading zero: it and
   // every digit above it are zero. Digit 0 is always shown.
   logic [DIGITS-1:0] lz_mask;
   logic [DIGITS-1:0] an_drive;
   logic [3:0]        nib_sel;
   logic              dp_sel;
   logic              lz_sel;
   logic              zeros_above;

   always_comb begin
      lz_mask     = '0;
      an_drive    = '1;
      nib_sel     = 4'h0;
      dp_sel      = 1'b0;
      lz_sel      = 1'b0;
      zeros_above = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zeros_above = zeros_above && (display_q[k*4 +: 4] == 4'h0);
         lz_mask[k]  = zeros_above && (k != 0);
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            nib_sel     = display_q[k*4 +: 4];
            dp_sel      = dp_in[k];
            lz_sel      = lz_mask[k];
            an_drive[k] = 1'b0;
         end
      end
   end

   // Registered outputs: they reflect the scan position one clock earlier,
   // and an/seg always change on the same edge.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         an          <= '1;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= boundary;
         if (in_blank) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
         end else begin
            an  <= an_drive;
            seg <= (lz_blank && lz_sel) ? 7'h7F : ~seg_decode(nib_sel);
            dp  <= ~dp_sel;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Drives directed and random strobes into seg7_scan_driver (DIGITS=4,
// SCAN_DIV=8, BLANK_CYCLES=2). The reference model works from an absolute
// clock count since reset: slot, tick and frame position are plain division
// and modulo of that count. Each driven clock pushes the expected
// {frame_start, an, seg, dp} into exp_q; the monitor pops one entry per clock
// just after the rising edge and compares.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int DIG = 4;
   localparam int SD  = 8;
   localparam int BL  = 2;
   localparam int FR  = SD * DIG;
   localparam int W   = 1 + DIG + 7 + 1;

   logic              clkIn = 1'b0;
   logic              rst_n = 1'b1;
   logic [4*DIG-1:0]  hex_in = '0;
   logic              hex_valid = 1'b0;
   logic [DIG-1:0]    dp_in = '0;
   logic              lz_blank = 1'b0;
   logic [6:0]        seg;
   logic              dp;
   logic [DIG-1:0]    an;
   logic              frame_start;

   seg7_scan_driver #(
      .DIGITS       (DIG),
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BL)
   ) dut (
      .clkIn       (clkIn),
      .rst_n       (rst_n),
      .hex_in      (hex_in),
      .hex_valid   (hex_valid),
      .dp_in       (dp_in),
      .lz_blank    (lz_blank),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .frame_start (frame_start)
   );

   // ---------------- clock ----------------
   always #5 clkIn = ~clkIn;

   // ---------------- scoreboard state ----------------
   logic [W-1:0]     exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   logic             mon_en   = 1'b0;

   // reference model state
   int               n = 0;
   logic [4*DIG-1:0] m_disp = '0;
   logic [4*DIG-1:0] m_pend = '0;
   logic             m_pflag = 1'b0;
   logic [6:0]       seg_tab [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected outputs after the next rising edge, from the current inputs and
   // the absolute edge number n.
   task automatic model_push();
      int               t;
      int               d;
      logic             bnd;
      logic [DIG-1:0]   e_an;
      logic [6:0]       e_seg;
      logic             e_dp;
      logic [3:0]       nib;
      logic             lead;
      t   = n % SD;
      d   = (n / SD) % DIG;
      bnd = ((n % FR) == FR - 1);
      if (t < BL) begin
         e_an  = '1;
         e_seg = 7'h7F;
         e_dp  = 1'b1;
      end else begin
         e_an    = '1;
         e_an[d] = 1'b0;
         nib     = 4'((m_disp >> (4 * d)) & 16'hF);
         lead    = (d != 0) && ((m_disp >> (4 * d)) == 0);
         e_seg   = (lz_blank && lead) ? 7'h7F : ~seg_tab[nib];
         e_dp    = ~dp_in[d];
      end
      exp_q.push_back({bnd, e_an, e_seg, e_dp});
      if (bnd) begin
         if (hex_valid)    m_disp = hex_in;
         else if (m_pflag) m_disp = m_pend;
         m_pflag = 1'b0;
      end else if (hex_valid) begin
         m_pend  = hex_in;
         m_pflag = 1'b1;
      end
      n++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic v, input logic [4*DIG-1:0] h);
      hex_valid = v;
      hex_in    = h;
      model_push();
      @(negedge clkIn);
      hex_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) cycle(1'b0, hex_in);
   endtask

   task automatic run_to(input int pos);
      while ((n % FR) != pos) cycle(1'b0, hex_in);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clkIn);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               check("frame_start", 32'(frame_start), 32'(e[W-1]));
               check("an",          32'(an),          32'(e[W-2 -: DIG]));
               check("seg",         32'(seg),         32'(e[7:1]));
               check("dp",          32'(dp),          32'(e[0]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      // reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_an",  32'(an),          32'hF);
      check("rst_seg", 32'(seg),         32'h7F);
      check("rst_dp",  32'(dp),          32'h1);
      check("rst_fs",  32'(frame_start), 32'h0);
      @(negedge clkIn);
      @(negedge clkIn);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // idle scan, digit "0" everywhere
      idle(2 * FR);

      // mid-frame strobe, shown from the next frame
      run_to(10);
      cycle(1'b1, 16'h8F1A);
      idle(2 * FR);

      // back-to-back strobes, last one wins
      run_to(5);
      cycle(1'b1, 16'h1111);
      idle(3);
      cycle(1'b1, 16'h2222);
      idle(FR);

      // strobe exactly on the boundary clock
      run_to(FR - 1);
      cycle(1'b1, 16'h3333);
      idle(FR);

      // leading-zero blanking
      lz_blank = 1'b1;
      run_to(3);
      cycle(1'b1, 16'h0050);
      idle(2 * FR);
      cycle(1'b1, 16'h0000);
      idle(2 * FR);
      lz_blank = 1'b0;
      idle(FR);

      // decimal point on digit 2
      dp_in = 4'b0100;
      idle(FR);
      dp_in = 4'b0000;

      // random traffic
      for (int i = 0; i < 30 * FR; i++) begin
         dp_in = DIG'($urandom_range(0, (1 << DIG) - 1));
         if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) cycle(1'b1, 16'($urandom) & 16'h00FF);
            else                           cycle(1'b1, 16'($urandom));
         end else begin
            cycle(1'b0, hex_in);
         end
      end

      // asynchronous reset at tick 5 of digit 2, with a pending value staged
      lz_blank = 1'b0;
      dp_in    = 4'b0100;
      run_to(2);
      cycle(1'b1, 16'h9999);
      run_to(2 * SD + 5);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_an",  32'(an),          32'hF);
      check("arst_seg", 32'(seg),         32'h7F);
      check("arst_dp",  32'(dp),          32'h1);
      check("arst_fs",  32'(frame_start), 32'h0);
      @(posedge clkIn);
      #1;
      check("arst_hold_an", 32'(an), 32'hF);
      @(negedge clkIn);
      rst_n   = 1'b1;
      exp_q.delete();
      n       = 0;
      m_disp  = '0;
      m_pend  = '0;
      m_pflag = 1'b0;
      dp_in   = 4'b0000;
      mon_en  = 1'b1;
      idle(3 * FR);

      mon_en = 1'b0;
      @(negedge clkIn);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
